// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared constants and types for the unified line-memory arbiter.
//   ADDR_WIDTH / LINE_WIDTH are the system-wide defaults; CH_IFETCH and
//   CH_DATA name the two fixed requesters of the core.
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int LINE_WIDTH = 256;

    localparam int CH_IFETCH  = 0;
    localparam int CH_DATA    = 1;

    // Channel ids are carried with a fixed width so the tag type does not
    // depend on NUM_CH (NUM_CH never exceeds 8).
    localparam int MAX_CH     = 8;
    localparam int CH_ID_W    = 3;

    typedef struct packed {
        logic               valid;
        logic [CH_ID_W-1:0] id;
    } rsp_tag_t;

    // Index width that stays legal for a single channel.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Requester-side and memory-side signals of the arbiter.
//   slave  : arbiter view (takes requests, drives grants/responses and the
//            memory command, receives memory read data)
//   master : environment view (requesters plus memory)
//   ch_addr / ch_wdata are flat vectors, channel i at [i*W +: W].
interface mem_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_we;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*LINE_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_gnt;
    logic [NUM_CH-1:0]        ch_rvalid;
    logic [LINE_W-1:0]        ch_rdata;

    logic                     mem_ready;
    logic                     mem_read_op;
    logic                     mem_write_op;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LINE_W-1:0]        mem_data_o;
    logic [LINE_W-1:0]        mem_data_i;

    modport slave (
        input  ch_req, ch_we, ch_addr, ch_wdata, mem_ready, mem_data_i,
        output ch_gnt, ch_rvalid, ch_rdata,
               mem_read_op, mem_write_op, mem_addr, mem_data_o
    );

    modport master (
        output ch_req, ch_we, ch_addr, ch_wdata, mem_ready, mem_data_i,
        input  ch_gnt, ch_rvalid, ch_rdata,
               mem_read_op, mem_write_op, mem_addr, mem_data_o
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin selector. Priority starts at ptr+1 and wraps
//   from NUM_CH-1 to 0; ptr itself has lowest priority.
//   req  in  : eligible requests
//   ptr  in  : index of the last granted channel
//   gnt  out : one-hot-or-zero grant
//   idx  out : index of the granted channel (0 when none)
//   any  out : a grant is issued
module rr_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic [NUM_CH-1:0] upper;
    logic [NUM_CH-1:0] sel;

    // Requests strictly above ptr win first; if none, fall back to the lowest
    // request overall, which is the wrap-around half of the ring.
    always_comb begin
        upper = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            upper[i] = req[i] && (i > int'(ptr));
        end
        sel = (upper != '0) ? upper : req;

        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel[i] && !any) begin
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one fixed-latency, pipelined line memory between NUM_CH
//   requesters (0 = instruction fetch, 1 = data). One round-robin grant per
//   cycle; the granted op is registered into the memory command stage and
//   reads are tracked by a tag pipeline so read data is routed back to the
//   issuing channel, in issue order.
//   clk   in : clock, rising edge
//   rst_n in : asynchronous active-low reset
//   bus      : mem_arbiter_if.slave (requester handshake + memory port)
//   Timing: grant in cycle T, memory strobe T+1, mem_data_i T+1+MEM_LAT,
//   ch_rvalid/ch_rdata T+2+MEM_LAT.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = ADDR_WIDTH,
    parameter int LINE_W  = LINE_WIDTH,
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    mem_arbiter_if.slave bus
);

    localparam int IDX_W = idx_width(NUM_CH);

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_any;
    logic [IDX_W-1:0]  ptr;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_wdata;

    rsp_tag_t          tag_q [0:MEM_LAT];
    logic [NUM_CH-1:0] rvalid_next;

    // No grant at all while the memory is not ready.
    assign eligible = bus.ch_req & {NUM_CH{bus.mem_ready}};

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req (eligible),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign bus.ch_gnt = gnt;

    // One-hot AND-OR mux of the granted channel's command.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt[i]) begin
                sel_we    = bus.ch_we[i];
                sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = bus.ch_wdata[i*LINE_W +: LINE_W];
            end
        end
    end

    // Reset value NUM_CH-1 makes channel 0 the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDX_W'(NUM_CH - 1);
        end else if (gnt_any) begin
            ptr <= gnt_idx;
        end
    end

    // Issue stage: strobes pulse for one cycle; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mem_read_op  <= 1'b0;
            bus.mem_write_op <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_data_o   <= '0;
        end else begin
            bus.mem_read_op  <= gnt_any && !sel_we;
            bus.mem_write_op <= gnt_any && sel_we;
            if (gnt_any) begin
                bus.mem_addr   <= sel_addr;
                bus.mem_data_o <= sel_wdata;
            end
        end
    end

    // tag_q[k] is live in cycle T+1+k, so tag_q[MEM_LAT] lines up with the
    // cycle in which mem_data_i carries that read's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= MEM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0].valid <= gnt_any && !sel_we;
            tag_q[0].id    <= CH_ID_W'(gnt_idx);
            for (int k = 1; k <= MEM_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_comb begin
        rvalid_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rvalid_next[i] = tag_q[MEM_LAT].valid &&
                             (tag_q[MEM_LAT].id == CH_ID_W'(i));
        end
    end

    // Response register: ch_rdata keeps the last returned line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ch_rvalid <= '0;
            bus.ch_rdata  <= '0;
        end else begin
            bus.ch_rvalid <= rvalid_next;
            if (tag_q[MEM_LAT].valid) begin
                bus.ch_rdata <= bus.mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter with NUM_CH=4, MEM_LAT=3. The bench
//   plays both the requesters and the line memory. Expected grants come from
//   a ring-search over the request vector; expected read data comes from a
//   reference memory updated in grant order, kept apart from the memory the
//   DUT actually talks to.
module tb_mem_arbiter;

    localparam int NUM_CH  = 4;
    localparam int ADDR_W  = 16;
    localparam int LINE_W  = 64;
    localparam int MEM_LAT = 3;
    localparam int RING    = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    mem_arbiter #(
        .NUM_CH  (NUM_CH),
        .ADDR_W  (ADDR_W),
        .LINE_W  (LINE_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [LINE_W-1:0] phys_mem [logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
    logic [LINE_W-1:0] sched    [RING];
    logic              sched_v  [RING];
    logic [NUM_CH-1:0] exp_rv   [RING];
    logic [LINE_W-1:0] exp_rd   [RING];

    int                last_ch;
    logic              cur_rop, cur_wop, nxt_rop, nxt_wop;
    logic [ADDR_W-1:0] cur_addr, nxt_addr;
    logic [LINE_W-1:0] cur_data, nxt_data, last_rdata;
    logic [NUM_CH-1:0] last_gnt;

    function automatic logic [LINE_W-1:0] fill(input logic [ADDR_W-1:0] a);
        return {4{a}};
    endfunction

    function automatic logic [LINE_W-1:0] phys_rd(input logic [ADDR_W-1:0] a);
        if (phys_mem.exists(a)) return phys_mem[a];
        return fill(a);
    endfunction

    function automatic logic [LINE_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return fill(a);
    endfunction

    // First requesting channel after `last`, going round the ring.
    function automatic int pick(input logic [NUM_CH-1:0] r, input int last);
        int i;
        for (int k = 1; k <= NUM_CH; k++) begin
            i = (last + k) % NUM_CH;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cur_rop = 0; cur_wop = 0; nxt_rop = 0; nxt_wop = 0;
        cur_addr = '0; nxt_addr = '0;
        cur_data = '0; nxt_data = '0;
        last_rdata = '0;
        last_ch = NUM_CH - 1;
        last_gnt = '0;
        for (int k = 0; k < RING; k++) exp_rv[k] = '0;
    endtask

    task automatic set_ch(input int i, input logic req, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d);
        bus.ch_req[i] = req;
        bus.ch_we[i]  = we;
        bus.ch_addr[i*ADDR_W +: ADDR_W]  = a;
        bus.ch_wdata[i*LINE_W +: LINE_W] = d;
    endtask

    // Move to just after the next rising edge and present memory read data
    // scheduled for the new cycle.
    task automatic advance();
        int s;
        @(posedge clk);
        #1;
        cyc++;
        cur_rop = nxt_rop; cur_wop = nxt_wop;
        cur_addr = nxt_addr; cur_data = nxt_data;
        s = cyc % RING;
        bus.mem_data_i = sched_v[s] ? sched[s] : {$urandom, $urandom};
        sched_v[s] = 1'b0;
    endtask

    task automatic step();
        logic [NUM_CH-1:0] eff, g;
        logic [ADDR_W-1:0] a;
        logic [LINE_W-1:0] wd;
        int gi, s;
        @(negedge clk);
        s   = cyc % RING;
        eff = bus.ch_req & {NUM_CH{bus.mem_ready}};
        gi  = pick(eff, last_ch);
        g   = '0;
        if (gi >= 0) g[gi] = 1'b1;

        chk("ch_gnt",       64'(bus.ch_gnt),       64'(g));
        chk("mem_read_op",  64'(bus.mem_read_op),  64'(cur_rop));
        chk("mem_write_op", 64'(bus.mem_write_op), 64'(cur_wop));
        chk("mem_addr",     64'(bus.mem_addr),     64'(cur_addr));
        chk("mem_data_o",   bus.mem_data_o,        cur_data);
        if (exp_rv[s] != '0) last_rdata = exp_rd[s];
        chk("ch_rvalid",    64'(bus.ch_rvalid),    64'(exp_rv[s]));
        chk("ch_rdata",     bus.ch_rdata,          last_rdata);
        exp_rv[s] = '0;

        if (bus.mem_write_op) phys_mem[bus.mem_addr] = bus.mem_data_o;
        if (bus.mem_read_op) begin
            sched[(cyc + MEM_LAT) % RING]   = phys_rd(bus.mem_addr);
            sched_v[(cyc + MEM_LAT) % RING] = 1'b1;
        end

        nxt_rop = 0; nxt_wop = 0;
        nxt_addr = cur_addr; nxt_data = cur_data;
        if (gi >= 0) begin
            last_ch  = gi;
            a        = bus.ch_addr[gi*ADDR_W +: ADDR_W];
            wd       = bus.ch_wdata[gi*LINE_W +: LINE_W];
            nxt_addr = a;
            nxt_data = wd;
            if (bus.ch_we[gi]) begin
                nxt_wop    = 1;
                ref_mem[a] = wd;
            end else begin
                nxt_rop = 1;
                exp_rv[(cyc + 2 + MEM_LAT) % RING] = g;
                exp_rd[(cyc + 2 + MEM_LAT) % RING] = ref_rd(a);
            end
        end
        last_gnt = g;
        advance();
    endtask

    task automatic idle(input int n);
        bus.ch_req = '0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic reset_phase(input int n);
        rst_n = 1'b0;
        bus.ch_req = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("rst_ch_gnt",       64'(bus.ch_gnt),       64'd0);
            chk("rst_ch_rvalid",    64'(bus.ch_rvalid),    64'd0);
            chk("rst_ch_rdata",     bus.ch_rdata,          64'd0);
            chk("rst_mem_read_op",  64'(bus.mem_read_op),  64'd0);
            chk("rst_mem_write_op", 64'(bus.mem_write_op), 64'd0);
            chk("rst_mem_addr",     64'(bus.mem_addr),     64'd0);
            chk("rst_mem_data_o",   bus.mem_data_o,        64'd0);
            advance();
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bus.ch_req     = '0;
        bus.ch_we      = '0;
        bus.ch_addr    = '0;
        bus.ch_wdata   = '0;
        bus.mem_ready  = 1'b1;
        bus.mem_data_i = '0;
        for (int k = 0; k < RING; k++) begin
            sched_v[k] = 1'b0;
            sched[k]   = '0;
            exp_rd[k]  = '0;
        end
        model_reset();
        phys_mem[16'h0040] = 64'hA5A5_A5A5_A5A5_A5A5;
        ref_mem[16'h0040]  = 64'hA5A5_A5A5_A5A5_A5A5;

        reset_phase(2);

        // Contention from reset: 0,1,0,1.
        set_ch(0, 1'b1, 1'b0, 16'h0100, 64'h1);
        set_ch(1, 1'b1, 1'b0, 16'h0200, 64'h2);
        for (int k = 0; k < 4; k++) step();
        idle(6);

        // Single read of 0x40 by channel 0.
        set_ch(0, 1'b1, 1'b0, 16'h0040, 64'h0);
        step();
        idle(7);

        // Backpressure: one read in flight, ch1 waits through 3 stalled cycles.
        set_ch(0, 1'b1, 1'b0, 16'h0100, 64'h0);
        step();
        bus.ch_req = '0;
        set_ch(1, 1'b1, 1'b0, 16'h0040, 64'h0);
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) step();
        bus.mem_ready = 1'b1;
        step();
        idle(6);

        // Read after write across channels.
        set_ch(1, 1'b1, 1'b1, 16'h0080, 64'hDEAD);
        step();
        bus.ch_req = '0;
        set_ch(0, 1'b1, 1'b0, 16'h0080, 64'h0);
        step();
        idle(6);

        // All channels streaming reads.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < NUM_CH; i++)
                set_ch(i, 1'b1, 1'b0, ADDR_W'($urandom_range(0, 15) << 4), {$urandom, $urandom});
            step();
        end

        // Reset with two reads in flight; nothing may come back afterwards.
        bus.ch_req = '0;
        set_ch(0, 1'b1, 1'b0, 16'h0040, 64'h0);
        step();
        bus.ch_req = '0;
        set_ch(1, 1'b1, 1'b0, 16'h0080, 64'h0);
        step();
        reset_phase(2);
        idle(8);

        // Randomised traffic; requests mostly held until granted.
        for (int n = 0; n < 400; n++) begin
            bus.mem_ready = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!(bus.ch_req[i] && !last_gnt[i] && ($urandom_range(0, 9) != 0)))
                    set_ch(i, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                           ADDR_W'($urandom_range(0, 7) << 4), {$urandom, $urandom});
            end
            step();
        end
        bus.mem_ready = 1'b1;
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised successor to the fixed ROM/RAM split at the top level: multiplexes NUM_CH requesters (channel 0 = instruction fetch, channel 1 = data, further channels optional) onto one shared line-wide memory port. Round-robin arbitration, one grant per cycle, fixed-latency pipelined memory with in-order response routing by channel tag. Sits between `core` and a unified line memory inside the top-level `RISC_V` wrapper.

## Interface
- NUM_CH, default 2: requester channels, 1..8.
- ADDR_W, default 32: byte address width (matches `ADDR_WIDTH).
- LINE_W, default 256: line data width.
- MEM_LAT, default 1: memory read latency in cycles, ≥1.
- CLK  in  1: single clock, rising edge.
- RST  in  1: reset, asynchronous, active-low.
- ch_req  in  NUM_CH: per-channel request, held until granted.
- ch_we  in  NUM_CH: 1 = write, 0 = read.
- ch_addr  in  NUM_CH*ADDR_W: channel i at [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*LINE_W: channel i at [i*LINE_W +: LINE_W].
- ch_gnt  out  NUM_CH: one-hot-or-zero acceptance, combinational.
- ch_rvalid  out  NUM_CH: one-hot-or-zero read-data valid, registered.
- ch_rdata  out  LINE_W: shared read data, qualified by ch_rvalid.
- mem_ready  in  1: memory can accept an op this cycle.
- mem_read_op  out  1: registered read strobe.
- mem_write_op  out  1: registered write strobe.
- mem_addr  out  ADDR_W: registered address.
- mem_data_o  out  LINE_W: registered write data.
- mem_data_i  in  LINE_W: read data, valid exactly MEM_LAT cycles after the mem_read_op cycle.

## Operation
- Eligible set = ch_req & {NUM_CH{mem_ready}}; grant chosen round-robin starting at ptr+1 mod NUM_CH, wrapping NUM_CH-1 → 0.
- ch_gnt[i]=1 in the same cycle as the selection; req∧gnt at the edge = transfer; requester may change addr/we/wdata next cycle.
- ptr updates to granted index only on a grant; unchanged in idle cycles.
- Request dropped before gnt: legal, no transfer, no side effects.
- Granted op registered into issue stage: next cycle mem_read_op or mem_write_op = 1 with addr/data; otherwise both strobes 0, addr/data hold last value.
- Reads push {valid, channel id} into a tag shift register of depth MEM_LAT+1; at tag exit, ch_rvalid[id] and ch_rdata ← mem_data_i are registered.
- Writes: no response; gnt is completion from requester's view.
- Order: issue order = grant order; responses return in issue order; read after write to same address from any channel observes new data.
- NUM_CH=1: pointer degenerate, grant = req & mem_ready.
- Reset values: ptr = NUM_CH-1 (channel 0 first), strobes 0, mem_addr 0, mem_data_o 0, tags invalid, ch_rvalid 0, ch_rdata 0.
- Reset mid-operation: in-flight tags discarded; no ch_rvalid after RST deasserts for ops issued before reset.

## Timing
- Cycle T: req∧gnt. T+1: mem strobe. T+1+MEM_LAT: mem_data_i valid. T+2+MEM_LAT: ch_rvalid/ch_rdata for one cycle.
- Throughput: one op per cycle while mem_ready=1; mem_ready=0 blocks all grants that cycle, in-flight reads still complete.
- No combinational path from mem_data_i to any output; only ch_req/mem_ready → ch_gnt is combinational.

## Structure
- ADDR_WIDTH, LINE_WIDTH, channel-index constants (CH_IFETCH=0, CH_DATA=1) in shared `config.vh`.
- Sub-module `rr_arbiter` (NUM_CH param; req, ptr → one-hot gnt, granted index); pointer register and tag pipeline stay in mem_arbiter.

## Test plan
- Reset: RST low mid-stream with 2 reads in flight → all outputs 0, no ch_rvalid after release.
- Single read, MEM_LAT=1: ch0 read addr 0x40 at T, memory returns 0xA5..A5 → mem_read_op at T+1, ch_rvalid=01 with data at T+3.
- Contention: ch0 and ch1 reqs held 4 cycles from reset → grants 0,1,0,1; ptr wraps 1→0.
- Backpressure: mem_ready=0 for 3 cycles with ch1 pending → ch_gnt=0 those cycles, grant on first mem_ready=1 cycle, pending responses unaffected.
- RAW: ch1 writes 0xDEAD to 0x80 at T, ch0 reads 0x80 at T+1 → read returns 0xDEAD on ch_rvalid[0].
- NUM_CH=4, MEM_LAT=3: all channels streaming reads back-to-back → 1 rvalid/cycle, ids 0,1,2,3 repeating, each 5 cycles after grant.
